// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant signal bundle between bus sources and the arbiter
interface bus_arbiter_if #(
   parameter int Bus_length = 32
);
   localparam int IDW = (Bus_length > 1) ? $clog2(Bus_length) : 1;

   logic [Bus_length-1:0] req;
   logic [Bus_length-1:0] sel_lines;
   logic [IDW-1:0]        grant_id;
   logic                  bus_busy;

   // Sources drive requests and observe the grant
   modport master (
      output req,
      input  sel_lines,
      input  grant_id,
      input  bus_busy
   );

   // The arbiter consumes requests and drives the grant
   modport slave (
      input  req,
      output sel_lines,
      output grant_id,
      output bus_busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin one-hot bus arbiter with hold limit and turnaround cycle
module bus_arbiter #(
   parameter int Bus_length = 32,
   parameter int HOLD_MAX   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_arbiter_if.slave  bus
);
   localparam int IDW = (Bus_length > 1) ? $clog2(Bus_length) : 1;
   localparam int HW  = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

   localparam logic [IDW:0]   N_W        = (IDW + 1)'(Bus_length);
   localparam logic [IDW-1:0] LAST_IDX   = IDW'(Bus_length - 1);
   localparam logic [HW-1:0]  HOLD_MAX_W = HW'(HOLD_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [Bus_length-1:0] sel_q, sel_n;
   logic [IDW-1:0]        gid_q, gid_n;
   logic                  busy_q, busy_n;
   logic [IDW-1:0]        rr_ptr, rr_n;
   logic [HW-1:0]         hold_cnt, hold_n;

   logic                  pick_valid;
   logic [IDW-1:0]        pick_idx;
   logic [IDW:0]          scan;

   assign bus.sel_lines = sel_q;
   assign bus.grant_id  = gid_q;
   assign bus.bus_busy  = busy_q;

   // Round-robin search starting at rr_ptr; scanning backwards lets the closest requester win last
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan       = '0;
      for (int k = Bus_length - 1; k >= 0; k--) begin
         scan = {1'b0, rr_ptr} + (IDW + 1)'(k);
         if (scan >= N_W) begin
            scan = scan - N_W;
         end
         if (bus.req[scan[IDW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = scan[IDW-1:0];
         end
      end
   end

   // Next-state and next-output logic; outputs are registered so sel_lines never glitches
   always_comb begin
      state_n = state;
      sel_n   = sel_q;
      gid_n   = gid_q;
      busy_n  = busy_q;
      rr_n    = rr_ptr;
      hold_n  = hold_cnt;
      case (state)
         IDLE, TURN: begin
            if (pick_valid) begin
               state_n = GRANT;
               sel_n   = Bus_length'(1) << pick_idx;
               gid_n   = pick_idx;
               busy_n  = 1'b1;
               hold_n  = HW'(1);
               rr_n    = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDW'(1);
            end else begin
               state_n = IDLE;
               sel_n   = '0;
               gid_n   = '0;
               busy_n  = 1'b0;
               hold_n  = '0;
            end
         end
         GRANT: begin
            // Only the owner's own request and the hold budget decide release
            if (bus.req[gid_q] && (hold_cnt < HOLD_MAX_W)) begin
               hold_n = hold_cnt + HW'(1);
            end else begin
               state_n = TURN;
               sel_n   = '0;
               gid_n   = '0;
               busy_n  = 1'b0;
               hold_n  = '0;
            end
         end
         default: begin
            state_n = IDLE;
            sel_n   = '0;
            gid_n   = '0;
            busy_n  = 1'b0;
            hold_n  = '0;
         end
      endcase
   end

   // State and output registers; reset drops the grant immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel_q    <= '0;
         gid_q    <= '0;
         busy_q   <= 1'b0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         sel_q    <= sel_n;
         gid_q    <= gid_n;
         busy_q   <= busy_n;
         rr_ptr   <= rr_n;
         hold_cnt <= hold_n;
      end
   end
endmodule
